// File: rtl/muldiv_unit_if.sv
// Request/response bundle for the multiply/divide unit.
// master: issues requests and consumes results (pipeline side).
// slave : the muldiv_unit itself.
// Signals: in_valid/in_ready/src1/src2/func3 request handshake, flush pipeline
// kill, out_valid/out_ready/result response handshake, busy status.
interface muldiv_unit_if #(
  parameter int unsigned XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [XLEN-1:0] src1;
  logic [XLEN-1:0] src2;
  logic [2:0]      func3;
  logic            flush;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] result;
  logic            busy;

  modport master (
    output in_valid, src1, src2, func3, flush, out_ready,
    input  in_ready, out_valid, result, busy
  );

  modport slave (
    input  in_valid, src1, src2, func3, flush, out_ready,
    output in_ready, out_valid, result, busy
  );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative RISC-V M-extension unit: one op in flight, multi-cycle multiply
// and restoring radix-2 divide.
// Ports: clk, rst (async active-high), bus (muldiv_unit_if.slave) carrying
// the request handshake, flush, result handshake and busy.
module muldiv_unit #(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned MUL_STAGES = 2
) (
  input  logic         clk,
  input  logic         rst,
  muldiv_unit_if.slave bus
);
  localparam int unsigned CW = $clog2(XLEN) + 1;
  localparam int unsigned PW = 2 * XLEN;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2:0]      op_q, op_d;
  logic [XLEN-1:0] src1_q, src1_d;
  logic [XLEN-1:0] src2_q, src2_d;
  logic [XLEN-1:0] a_q, a_d;     // |src1|, becomes the quotient while dividing
  logic [XLEN-1:0] b_q, b_d;     // |src2|
  logic [XLEN-1:0] rem_q, rem_d;
  logic [XLEN-1:0] result_q, result_d;
  logic            in_ready_q, in_ready_d;
  logic            out_valid_q, out_valid_d;
  logic            busy_q, busy_d;

  // Operand signedness per func3: MULH s*s, MULHSU s*u, DIV/REM signed.
  function automatic logic sign1(input logic [2:0] f);
    return f[2] ? ~f[0] : (f[1] ^ f[0]);
  endfunction

  function automatic logic sign2(input logic [2:0] f);
    return f[2] ? ~f[0] : (f[1:0] == 2'b01);
  endfunction

  logic            neg1_in, neg2_in;
  logic [XLEN-1:0] mag1_in, mag2_in;
  logic            neg1_q, neg2_q;
  logic [PW-1:0]   prod_mag, prod;
  logic [XLEN-1:0] mul_res;
  logic [XLEN:0]   shifted, diff;
  logic            div_ge;
  logic            div_signed, div_zero, div_ovf;
  logic [XLEN-1:0] quo_fix, rem_fix;
  logic            first_div;

  // Magnitudes captured at accept so MUL and DIV share one unsigned datapath.
  always_comb begin
    neg1_in = sign1(bus.func3) & bus.src1[XLEN-1];
    neg2_in = sign2(bus.func3) & bus.src2[XLEN-1];
    mag1_in = neg1_in ? -bus.src1 : bus.src1;
    mag2_in = neg2_in ? -bus.src2 : bus.src2;
  end

  // Magnitude multiply with sign correction; MUL keeps low half, others high.
  always_comb begin
    neg1_q   = sign1(op_q) & src1_q[XLEN-1];
    neg2_q   = sign2(op_q) & src2_q[XLEN-1];
    prod_mag = PW'(a_q) * PW'(b_q);
    prod     = (neg1_q ^ neg2_q) ? -prod_mag : prod_mag;
    mul_res  = (op_q[1:0] == 2'b00) ? prod[XLEN-1:0] : prod[PW-1:XLEN];
  end

  // One restoring step: shift dividend bit into partial remainder, try subtract.
  always_comb begin
    shifted    = {rem_q, a_q[XLEN-1]};
    diff       = shifted - {1'b0, b_q};
    div_ge     = ~diff[XLEN];
    div_signed = ~op_q[0];
    div_zero   = (src2_q == '0);
    div_ovf    = div_signed && (src1_q == {1'b1, {(XLEN-1){1'b0}}}) && (src2_q == '1);
    quo_fix    = (div_signed && (src1_q[XLEN-1] ^ src2_q[XLEN-1])) ? -a_q : a_q;
    rem_fix    = (div_signed && src1_q[XLEN-1]) ? -rem_q : rem_q;
    first_div  = (cnt_q == CW'(XLEN));
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    src1_d   = src1_q;
    src2_d   = src2_q;
    a_d      = a_q;
    b_d      = b_q;
    rem_d    = rem_q;
    result_d = result_q;

    unique case (state_q)
      S_IDLE: begin
        if (bus.in_valid && !bus.flush) begin
          op_d   = bus.func3;
          src1_d = bus.src1;
          src2_d = bus.src2;
          a_d    = mag1_in;
          b_d    = mag2_in;
          rem_d  = '0;
          if (bus.func3[2]) begin
            state_d = S_DIV;
            cnt_d   = CW'(XLEN);
          end else begin
            state_d = S_MUL;
            cnt_d   = CW'(MUL_STAGES - 1);
          end
        end
      end
      S_MUL: begin
        if (cnt_q == '0) begin
          state_d  = S_DONE;
          result_d = mul_res;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_DIV: begin
        // Special cases resolve on the first DIV cycle from registered operands.
        if (first_div && div_zero) begin
          state_d  = S_DONE;
          cnt_d    = '0;
          result_d = op_q[1] ? src1_q : '1;
        end else if (first_div && div_ovf) begin
          state_d  = S_DONE;
          cnt_d    = '0;
          result_d = op_q[1] ? '0 : src1_q;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - CW'(1);
          rem_d = div_ge ? diff[XLEN-1:0] : shifted[XLEN-1:0];
          a_d   = {a_q[XLEN-2:0], div_ge};
        end else begin
          state_d  = S_DONE;
          result_d = op_q[1] ? rem_fix : quo_fix;
        end
      end
      S_DONE: begin
        if (bus.out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Flush wins over accept and over a result handshake.
    if (bus.flush) begin
      state_d = S_IDLE;
      cnt_d   = '0;
    end

    in_ready_d  = (state_d == S_IDLE);
    out_valid_d = (state_d == S_DONE);
    busy_d      = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      op_q        <= '0;
      src1_q      <= '0;
      src2_q      <= '0;
      a_q         <= '0;
      b_q         <= '0;
      rem_q       <= '0;
      result_q    <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      op_q        <= op_d;
      src1_q      <= src1_d;
      src2_q      <= src2_d;
      a_q         <= a_d;
      b_q         <= b_d;
      rem_q       <= rem_d;
      result_q    <= result_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.result    = result_q;
  assign bus.busy      = busy_q;
endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 Parameter XLEN, default 32, operand/result width (legal: 32, 64).
REQ-002 Parameter MUL_STAGES, default 2, multiply latency in cycles (legal: 1..4).
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 in_valid  input  1  request present.
REQ-006 in_ready  output  1  unit can accept a request.
REQ-007 src1  input  XLEN  operand rs1.
REQ-008 src2  input  XLEN  operand rs2.
REQ-009 func3  input  3  op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-010 flush  input  1  abort in-flight op (pipeline kill).
REQ-011 out_valid  output  1  result available.
REQ-012 out_ready  input  1  consumer takes result.
REQ-013 result  output  XLEN  operation result.
REQ-014 busy  output  1  high whenever state is not IDLE.

Function
REQ-015 States SHALL be IDLE, MUL, DIV, DONE; one operation in flight at a time.
REQ-016 in_ready SHALL equal (state==IDLE); accept occurs on a rising edge with in_valid && in_ready && !flush.
REQ-017 On accept, src1, src2, func3 SHALL be registered; inputs are don't-care afterwards.
REQ-018 Accepted func3[2]==0 SHALL go to MUL; a cycle counter loads MUL_STAGES-1, decrements each cycle, and at 0 transitions to DONE (out_valid high exactly MUL_STAGES cycles after accept).
REQ-019 MUL SHALL form the 2*XLEN product with signedness per op (MULH s*s, MULHSU s*u, MULHU/MUL u*u) using magnitude multiply plus sign correction; MUL returns low XLEN bits, others high XLEN bits.
REQ-020 Accepted DIV/DIVU/REM/REMU with src2==0 SHALL go directly to DONE (latency 1): quotient all-ones, remainder = src1.
REQ-021 Accepted DIV/REM with src1 = most-negative and src2 = all-ones SHALL go directly to DONE (latency 1): quotient = src1, remainder = 0.
REQ-022 Otherwise divide SHALL run restoring radix-2 on magnitudes (signed ops) for exactly XLEN iterations in DIV, then one sign-fix cycle into DONE: latency XLEN+1 cycles from accept.
REQ-023 Signed quotient sign = sign(src1) xor sign(src2); signed remainder takes sign of src1; truncation toward zero.
REQ-024 In DONE, out_valid SHALL be 1 and result SHALL be stable until out_valid && out_ready; that edge returns to IDLE.
REQ-025 No back-to-back issue: in_ready SHALL be 0 in the cycle DONE is consumed and 1 the following cycle.
REQ-026 flush high at a rising edge SHALL force IDLE from any state, clear out_valid, discard the op; flush overrides a simultaneous accept and a simultaneous out_ready handshake (result counts as not delivered).
REQ-027 result SHALL hold its last value outside DONE; consumers use it only with out_valid.
REQ-028 Counter and iteration index SHALL be sized clog2(XLEN)+1 bits; no wrap beyond terminal count.

Reset
REQ-029 rst assertion SHALL immediately (asynchronously) set state IDLE, out_valid 0, busy 0, result 0, counters 0; in_ready reads 1.
REQ-030 rst mid-operation SHALL abandon the op with no result ever emitted for it.
REQ-031 First accept possible on the first rising edge after rst deasserts.

Verification
REQ-032 XLEN=32, MUL_STAGES=2: MULH src1=0xFFFFFFFF src2=0x00000002 -> out_valid 2 cycles after accept, result 0xFFFFFFFF; MULHU same operands -> 0x00000001.
REQ-033 DIV src1=0xFFFFFFF9 (-7) src2=2 -> result 0xFFFFFFFD after 33 cycles; REM same -> 0xFFFFFFFF.
REQ-034 DIVU src1=5 src2=0 -> 0xFFFFFFFF after 1 cycle; REM src1=0x80000000 src2=0xFFFFFFFF -> 0x00000000 after 1 cycle.
REQ-035 Backpressure: out_ready held 0 for 5 cycles in DONE -> result and out_valid stable, in_ready 0; out_ready 1 -> IDLE, in_ready 1 next cycle.
REQ-036 flush asserted at iteration 10 of a DIV -> IDLE next edge, out_valid never asserts; new MUL 3*4 accepted next cycle -> 0x0000000C.
REQ-037 rst pulse mid-MUL and randomized compare against a reference model for all 8 ops at XLEN=32 and 64, MUL_STAGES 1 and 4.
